wb_queue: RTL and testbench

- Write-back queue on the producer side of the register-file write port.
- Accepts completed results from two execution sources (ALU, LSU) through valid/ready handshakes and buffers them in a small circular FIFO.
- Drains one entry per cycle onto the register file's single write port (we3/wa3/wd3).
- Forwards the youngest pending value for each of the two read addresses, so decode never reads stale register data.

---
 rtl/wb_queue.sv | 121 ++++++++++++
 tb/tb_wb_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU/LSU results in a small circular FIFO, drains one
// entry per cycle onto the register-file write port and forwards pending values.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [AW-1:0]            lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  output logic                     lsu_ready,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [XLEN-1:0]          wd3,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic                     fwd1_hit,
  output logic [XLEN-1:0]          fwd1_data,
  output logic                     fwd2_hit,
  output logic [XLEN-1:0]          fwd2_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_FULL = CW'(DEPTH - 1);

  logic [AW-1:0]   addr_q [DEPTH];
  logic [AW-1:0]   addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            alu_store;
  logic            lsu_store;
  logic            pop;
  logic [PW-1:0]   lsu_slot;

  // Readiness looks only at registered occupancy; the same-cycle drain earns no credit.
  always_comb begin
    alu_ready = (count_q < FULL);
    lsu_ready = (count_q < NEAR_FULL) || ((count_q < FULL) && !alu_valid);
  end

  always_comb begin
    alu_store = alu_valid && alu_ready && (alu_rd != '0);
    lsu_store = lsu_valid && lsu_ready && (lsu_rd != '0);
    pop       = (count_q != '0);
    lsu_slot  = alu_store ? tail_q + PW'(1) : tail_q;

    addr_d = addr_q;
    data_d = data_q;
    if (alu_store) begin
      addr_d[tail_q] = alu_rd;
      data_d[tail_q] = alu_data;
    end
    if (lsu_store) begin
      addr_d[lsu_slot] = lsu_rd;
      data_d[lsu_slot] = lsu_data;
    end

    tail_d  = tail_q + PW'(alu_store) + PW'(lsu_store);
    head_d  = pop ? head_q + PW'(1) : head_q;
    count_d = count_q + CW'(alu_store) + CW'(lsu_store) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset: nothing outside the live window is ever observed.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign we3   = (count_q != '0);
  assign wa3   = addr_q[head_q];
  assign wd3   = data_q[head_q];
  assign empty = (count_q == '0);
  assign count = count_q;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((ra1 != '0) && (addr_q[head_q + PW'(i)] == ra1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[head_q + PW'(i)];
        end
        if ((ra2 != '0) && (addr_q[head_q + PW'(i)] == ra2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[head_q + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: stimulus pushes expected register-file writes,
// a negedge monitor pops them as the DUT drains and checks all status outputs.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   alu_valid = 1'b0;
  logic [AW-1:0]          alu_rd = '0;
  logic [XLEN-1:0]        alu_data = '0;
  logic                   alu_ready;
  logic                   lsu_valid = 1'b0;
  logic [AW-1:0]          lsu_rd = '0;
  logic [XLEN-1:0]        lsu_data = '0;
  logic                   lsu_ready;
  logic                   we3;
  logic [AW-1:0]          wa3;
  logic [XLEN-1:0]        wd3;
  logic [AW-1:0]          ra1 = '0;
  logic [AW-1:0]          ra2 = '0;
  logic                   fwd1_hit;
  logic [XLEN-1:0]        fwd1_data;
  logic                   fwd2_hit;
  logic [XLEN-1:0]        fwd2_data;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     mon_en   = 1'b0;

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue of pending writes, in arrival order.
  function automatic bit exp_alu_ready();
    return exp_q.size() < DEPTH;
  endfunction

  function automatic bit exp_lsu_ready(input logic av);
    return (exp_q.size() < DEPTH - 1) || ((exp_q.size() < DEPTH) && !av);
  endfunction

  function automatic void fwd_lookup(input logic [AW-1:0] ra, output logic hit,
                                     output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != '0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].rd == ra) begin
          hit = 1'b1;
          d   = exp_q[i].data;
        end
      end
    end
  endfunction

  // Monitor: compares state-derived outputs, then retires the head entry the DUT is writing.
  always @(negedge clk) begin
    logic            h;
    logic [XLEN-1:0] d;
    entry_t          e;
    if (mon_en && rst_n) begin
      checkOutput("count", 64'(count), 64'(exp_q.size()));
      checkOutput("empty", 64'(empty), 64'(exp_q.size() == 0));
      checkOutput("alu_ready", 64'(alu_ready), 64'(exp_alu_ready()));
      checkOutput("lsu_ready", 64'(lsu_ready), 64'(exp_lsu_ready(alu_valid)));
      fwd_lookup(ra1, h, d);
      checkOutput("fwd1_hit", 64'(fwd1_hit), 64'(h));
      checkOutput("fwd1_data", 64'(fwd1_data), 64'(d));
      fwd_lookup(ra2, h, d);
      checkOutput("fwd2_hit", 64'(fwd2_hit), 64'(h));
      checkOutput("fwd2_data", 64'(fwd2_data), 64'(d));
      checkOutput("we3", 64'(we3), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (we3) begin
          checkOutput("wa3", 64'(wa3), 64'(e.rd));
          checkOutput("wd3", 64'(wd3), 64'(e.data));
        end
      end
    end
  end

  // Called just after a rising edge; drives one cycle and records what the model accepts.
  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                               input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               output bit a_acc, output bit l_acc);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
    ra1       = r1;
    ra2       = r2;
    a_acc = av && exp_alu_ready();
    l_acc = lv && exp_lsu_ready(av);
    @(posedge clk);
    #1;
    if (a_acc && (ard != '0)) exp_q.push_back(entry_t'{rd: ard, data: ad});
    if (l_acc && (lrd != '0)) exp_q.push_back(entry_t'{rd: lrd, data: ld});
  endtask

  task automatic idle(input int n, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit a, l;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, r1, r2, a, l);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit              a_acc, l_acc;
    logic            av, lv;
    logic [AW-1:0]   ard, lrd;
    logic [XLEN-1:0] ad, ld;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_we3", 64'(we3), 64'(0));
    checkOutput("reset_empty", 64'(empty), 64'(1));
    checkOutput("reset_count", 64'(count), 64'(0));
    checkOutput("reset_alu_ready", 64'(alu_ready), 64'(1));
    checkOutput("reset_lsu_ready", 64'(lsu_ready), 64'(1));
    checkOutput("reset_fwd1_hit", 64'(fwd1_hit), 64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(3, 5'd0, 5'd0);

    // Single ALU write with one-cycle latency
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 5'd0, a_acc, l_acc);
    idle(3, 5'd5, 5'd0);

    // Simultaneous ALU+LSU to the same rd: LSU is younger
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3, a_acc, l_acc);
    idle(3, 5'd3, 5'd0);

    // x0 results complete the handshake but are dropped
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, 5'd0, 5'd0, a_acc, l_acc);
    applyStimulus(1'b1, 5'd0, 32'h56, 1'b1, 5'd0, 32'h57, 5'd0, 5'd0, a_acc, l_acc);
    idle(2, 5'd0, 5'd0);

    // Back-to-back dual writes: occupancy climbs to 3, then LSU is held off
    ard = 5'd1; ad = 32'hA000_0001;
    lrd = 5'd2; ld = 32'hB000_0001;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, ard, ad, 1'b1, lrd, ld, ard, lrd, a_acc, l_acc);
      if (a_acc) begin ard = AW'(1 + (c % 6)); ad = ad + 32'h10; end
      if (l_acc) begin lrd = AW'(2 + (c % 5)); ld = ld + 32'h10; end
    end
    idle(5, 5'd1, 5'd2);

    // Reset in the middle of a drain
    applyStimulus(1'b1, 5'd7, 32'hC7, 1'b1, 5'd8, 32'hC8, 5'd7, 5'd8, a_acc, l_acc);
    applyStimulus(1'b1, 5'd9, 32'hC9, 1'b1, 5'd10, 32'hCA, 5'd9, 5'd10, a_acc, l_acc);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    ra1 = 5'd9;
    ra2 = 5'd10;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_we3", 64'(we3), 64'(0));
    checkOutput("midreset_count", 64'(count), 64'(0));
    checkOutput("midreset_fwd1_hit", 64'(fwd1_hit), 64'(0));
    checkOutput("midreset_fwd2_hit", 64'(fwd2_hit), 64'(0));
    checkOutput("midreset_empty", 64'(empty), 64'(1));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4, 5'd9, 5'd10);

    // Randomized traffic; producers hold a request until it transfers
    av = 1'b0; lv = 1'b0;
    ard = '0; lrd = '0; ad = '0; ld = '0;
    for (int c = 0; c < 400; c++) begin
      if (!av || a_acc) begin
        av  = ($urandom_range(0, 9) < 6);
        ard = AW'($urandom_range(0, 7));
        ad  = $urandom;
      end
      if (!lv || l_acc) begin
        lv  = ($urandom_range(0, 9) < 6);
        lrd = AW'($urandom_range(0, 7));
        ld  = $urandom;
      end
      applyStimulus(av, ard, ad, lv, lrd, ld,
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), a_acc, l_acc);
    end
    idle(6, 5'd0, 5'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
